// File: rtl/uv_apb_master.sv
// APB4 initiator: turns single-beat agent requests into APB setup/access phases and
// returns read data and error/timeout status on a valid/ready response channel.
module uv_apb_master #(
  parameter int ALEN    = 12,
  parameter int DLEN    = 32,
  parameter int MLEN    = DLEN / 8,
  parameter int TMO_CYC = 256,
  parameter int TMO_W   = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_vld_i,
  output logic            req_rdy_o,
  input  logic            req_write_i,
  input  logic [ALEN-1:0] req_addr_i,
  input  logic [DLEN-1:0] req_wdata_i,
  input  logic [MLEN-1:0] req_strb_i,
  input  logic [2:0]      req_prot_i,
  output logic            rsp_vld_o,
  input  logic            rsp_rdy_i,
  output logic [DLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            rsp_tmo_o,
  output logic            m_psel_o,
  output logic            m_penable_o,
  output logic [2:0]      m_pprot_o,
  output logic [ALEN-1:0] m_paddr_o,
  output logic [MLEN-1:0] m_pstrb_o,
  output logic            m_pwrite_o,
  output logic [DLEN-1:0] m_pwdata_o,
  input  logic [DLEN-1:0] m_prdata_i,
  input  logic            m_pready_i,
  input  logic            m_pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  localparam bit              TmoEn  = (TMO_CYC != 0);
  localparam logic [TMO_W-1:0] TmoLim = TMO_W'(TMO_CYC);

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  cnt_q, cnt_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [2:0]        pprot_q, pprot_d;
  logic [ALEN-1:0]   paddr_q, paddr_d;
  logic [MLEN-1:0]   pstrb_q, pstrb_d;
  logic              pwrite_q, pwrite_d;
  logic [DLEN-1:0]   pwdata_q, pwdata_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic [DLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_tmo_q, rsp_tmo_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pprot_q     <= '0;
      paddr_q     <= '0;
      pstrb_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pprot_q     <= pprot_d;
      paddr_q     <= paddr_d;
      pstrb_q     <= pstrb_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tmo_q   <= rsp_tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pprot_d     = pprot_q;
    paddr_d     = paddr_q;
    pstrb_d     = pstrb_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_vld_d   = rsp_vld_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tmo_d   = rsp_tmo_q;
    unique case (state_q)
      IDLE: begin
        if (req_vld_i) begin
          paddr_d  = req_addr_i;
          pwrite_d = req_write_i;
          pwdata_d = req_wdata_i;
          // APB4 requires all strobes low on reads
          pstrb_d  = req_write_i ? req_strb_i : '0;
          pprot_d  = req_prot_i;
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (m_pready_i) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_rdata_d = pwrite_q ? '0 : m_prdata_i;
          rsp_err_d   = m_pslverr_i;
          rsp_tmo_d   = 1'b0;
          rsp_vld_d   = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (TmoEn && cnt_d == TmoLim) begin
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            rsp_tmo_d   = 1'b1;
            rsp_vld_d   = 1'b1;
            state_d     = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_rdy_i) begin
          rsp_vld_d = 1'b0;
          cnt_d     = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_rdy_o   = (state_q == IDLE);
  assign rsp_vld_o   = rsp_vld_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_tmo_o   = rsp_tmo_q;
  assign m_psel_o    = psel_q;
  assign m_penable_o = penable_q;
  assign m_pprot_o   = pprot_q;
  assign m_paddr_o   = paddr_q;
  assign m_pstrb_o   = pstrb_q;
  assign m_pwrite_o  = pwrite_q;
  assign m_pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_uv_apb_master.sv
// Self-checking bench for uv_apb_master: transaction-level reference model compared every
// cycle, plus directed transfers with hand-computed latencies and response values.
module tb_uv_apb_master;

  localparam int TmoCyc = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqVld, reqRdy, reqWrite;
  logic [11:0] reqAddr;
  logic [31:0] reqWdata;
  logic [3:0]  reqStrb;
  logic [2:0]  reqProt;
  logic        rspVld, rspRdy, rspErr, rspTmo;
  logic [31:0] rspRdata;
  logic        mPsel, mPenable, mPwrite;
  logic [2:0]  mPprot;
  logic [11:0] mPaddr;
  logic [3:0]  mPstrb;
  logic [31:0] mPwdata;
  logic [31:0] mPrdata = 32'hDEAD_BEEF;
  logic        mPready = 1'b1;
  logic        mPslverr = 1'b0;

  int checks = 0;
  int errors = 0;

  // slave behaviour knobs
  int          slvWait  = 0;
  bit          slvStuck = 1'b0;
  bit          slvErr   = 1'b0;
  logic [31:0] slvData  = 32'h0;
  int          accCnt   = 0;

  // request presented while a response is still being held
  logic        nextWrite;
  logic [11:0] nextAddr;
  logic [31:0] nextWdata;
  logic [3:0]  nextStrb;
  logic [2:0]  nextProt;

  uv_apb_master #(.ALEN(12), .DLEN(32), .MLEN(4), .TMO_CYC(TmoCyc), .TMO_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_vld_i(reqVld), .req_rdy_o(reqRdy), .req_write_i(reqWrite),
    .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .req_strb_i(reqStrb), .req_prot_i(reqProt),
    .rsp_vld_o(rspVld), .rsp_rdy_i(rspRdy), .rsp_rdata_o(rspRdata),
    .rsp_err_o(rspErr), .rsp_tmo_o(rspTmo),
    .m_psel_o(mPsel), .m_penable_o(mPenable), .m_pprot_o(mPprot), .m_paddr_o(mPaddr),
    .m_pstrb_o(mPstrb), .m_pwrite_o(mPwrite), .m_pwdata_o(mPwdata),
    .m_prdata_i(mPrdata), .m_pready_i(mPready), .m_pslverr_i(mPslverr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: no DUT response within the cycle budget at %0t", name, $time);
  endtask

  // slave decides pready for the current cycle just after each edge; garbage data when not ready
  always @(posedge clk) begin
    #1;
    if (mPsel && mPenable) accCnt++;
    else accCnt = 0;
    if (slvStuck) mPready = 1'b0;
    else if (mPsel && mPenable && accCnt <= slvWait) mPready = 1'b0;
    else mPready = 1'b1;
    mPrdata  = (mPready && mPsel && mPenable) ? slvData : 32'hDEAD_BEEF;
    mPslverr = slvErr;
  end

  // reference model: a transfer is "busy" from accept until pready/timeout, first busy cycle is setup
  bit          modelLive = 1'b0;
  bit          mBusy, mResp;
  int          mAge, mWaitAcc;
  logic        eWrite;
  logic [11:0] eAddr;
  logic [31:0] eWdata, eRdata;
  logic [3:0]  eStrb;
  logic [2:0]  eProt;
  logic        eErr, eTmo;

  always @(posedge clk) begin
    modelLive = 1'b1;
    if (rst) begin
      mBusy = 0; mResp = 0; mAge = 0; mWaitAcc = 0;
      eWrite = 0; eAddr = 0; eWdata = 0; eStrb = 0; eProt = 0;
      eRdata = 0; eErr = 0; eTmo = 0;
    end else if (mResp) begin
      if (rspRdy) mResp = 0;
    end else if (!mBusy) begin
      if (reqVld) begin
        eWrite = reqWrite; eAddr = reqAddr; eWdata = reqWdata; eProt = reqProt;
        eStrb  = reqWrite ? reqStrb : 4'h0;
        mBusy = 1; mAge = 1; mWaitAcc = 0;
      end
    end else if (mAge == 1) begin
      mAge = 2;
    end else if (mPready) begin
      mBusy = 0; mResp = 1;
      eRdata = eWrite ? 32'h0 : mPrdata;
      eErr = mPslverr; eTmo = 0;
    end else begin
      mWaitAcc++;
      if (TmoCyc != 0 && mWaitAcc == TmoCyc) begin
        mBusy = 0; mResp = 1; eRdata = 0; eErr = 1; eTmo = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("req_rdy", reqRdy, !mBusy && !mResp);
      checkOutput("psel", mPsel, mBusy);
      checkOutput("penable", mPenable, mBusy && mAge >= 2);
      checkOutput("rsp_vld", rspVld, mResp);
      if (mBusy || mResp) begin
        checkOutput("paddr", mPaddr, eAddr);
        checkOutput("pwrite", mPwrite, eWrite);
        checkOutput("pwdata", mPwdata, eWdata);
        checkOutput("pstrb", mPstrb, eStrb);
        checkOutput("pprot", mPprot, eProt);
      end
      if (mResp) begin
        checkOutput("rsp_rdata", rspRdata, eRdata);
        checkOutput("rsp_err", rspErr, eErr);
        checkOutput("rsp_tmo", rspTmo, eTmo);
      end
    end
  end

  // one transfer; entered and left just after a rising edge; latencies are cycles after accept
  task automatic applyStimulus(
    input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
    input logic [3:0] strb, input logic [2:0] prot, input int rdyDelay, input bit holdNext,
    output logic [31:0] rdata, output logic err, output logic tmo,
    output int pselLat, output int penLat, output int rspLat,
    output int penCycles, output logic [3:0] strbSeen);
    int waitCnt;
    pselLat = -1; penLat = -1; rspLat = -1; penCycles = 0; strbSeen = 4'hF;
    rdata = 32'h0; err = 1'b0; tmo = 1'b0;
    reqWrite = wr; reqAddr = addr; reqWdata = wdata; reqStrb = strb; reqProt = prot;
    reqVld = 1'b1;
    waitCnt = 0;
    while (!reqRdy && waitCnt < 50) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!reqRdy) begin
      reportTimeout("accept_timeout");
      reqVld = 1'b0;
      return;
    end
    @(posedge clk); #1;
    reqVld = 1'b0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (mPsel && pselLat < 0) pselLat = c;
      if (mPenable && penLat < 0) penLat = c;
      if (mPenable) penCycles++;
      if (mPsel) strbSeen = mPstrb;
      if (rspVld) begin
        rspLat = c;
        break;
      end
    end
    if (rspLat < 0) begin
      reportTimeout("rsp_timeout");
      return;
    end
    rdata = rspRdata; err = rspErr; tmo = rspTmo;
    if (holdNext) begin
      reqWrite = nextWrite; reqAddr = nextAddr; reqWdata = nextWdata;
      reqStrb = nextStrb; reqProt = nextProt; reqVld = 1'b1;
    end
    if (rdyDelay == 0) rspRdy = 1'b1;
    else begin
      repeat (rdyDelay) @(posedge clk);
      #1 rspRdy = 1'b1;
    end
    @(posedge clk); #1;
    rspRdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er, tm;
    logic [3:0]  sb;
    int          pl, el, rl, pc;

    rst = 1'b1; reqVld = 1'b0; reqWrite = 1'b0; reqAddr = '0; reqWdata = '0;
    reqStrb = '0; reqProt = '0; rspRdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_req_rdy", reqRdy, 1);
    checkOutput("reset_psel", mPsel, 0);
    checkOutput("reset_penable", mPenable, 0);
    checkOutput("reset_rsp_vld", rspVld, 0);
    checkOutput("reset_paddr", mPaddr, 0);
    checkOutput("reset_rsp_rdata", rspRdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] write with pready held high");
    slvWait = 0;
    applyStimulus(1'b1, 12'h010, 32'hA5A5_0001, 4'hF, 3'b010, 0, 0, rd, er, tm, pl, el, rl, pc, sb);
    checkOutput("t1_psel_lat", pl, 1);
    checkOutput("t1_penable_lat", el, 2);
    checkOutput("t1_rsp_lat", rl, 3);
    checkOutput("t1_rdata", rd, 32'h0);
    checkOutput("t1_err", er, 0);

    $display("[TB] read with 3 wait states");
    slvWait = 3; slvData = 32'h0000_0042;
    applyStimulus(1'b0, 12'h004, 32'h1111_2222, 4'hF, 3'b000, 0, 0, rd, er, tm, pl, el, rl, pc, sb);
    checkOutput("t2_penable_cycles", pc, 4);
    checkOutput("t2_pstrb", sb, 4'h0);
    checkOutput("t2_rdata", rd, 32'h42);
    checkOutput("t2_rsp_lat", rl, 6);

    $display("[TB] write answered with slave error");
    slvWait = 0; slvErr = 1'b1;
    applyStimulus(1'b1, 12'h020, 32'h0BAD_F00D, 4'h3, 3'b001, 0, 0, rd, er, tm, pl, el, rl, pc, sb);
    checkOutput("t3_err", er, 1);
    checkOutput("t3_tmo", tm, 0);
    slvErr = 1'b0;

    $display("[TB] stuck slave, timeout");
    slvStuck = 1'b1;
    applyStimulus(1'b0, 12'h030, 32'h0, 4'h0, 3'b000, 0, 0, rd, er, tm, pl, el, rl, pc, sb);
    checkOutput("t4_penable_cycles", pc, 8);
    checkOutput("t4_rsp_lat", rl, 10);
    checkOutput("t4_err", er, 1);
    checkOutput("t4_tmo", tm, 1);
    checkOutput("t4_rdata", rd, 32'h0);
    slvStuck = 1'b0; slvData = 32'h1234_5678;
    applyStimulus(1'b0, 12'h008, 32'h0, 4'hF, 3'b100, 0, 0, rd, er, tm, pl, el, rl, pc, sb);
    checkOutput("t4_next_rdata", rd, 32'h1234_5678);
    checkOutput("t4_next_err", er, 0);
    checkOutput("t4_next_rsp_lat", rl, 3);

    $display("[TB] response back-pressure with a queued request");
    nextWrite = 1'b1; nextAddr = 12'h0FC; nextWdata = 32'hC0DE_0005; nextStrb = 4'hC; nextProt = 3'b011;
    applyStimulus(1'b1, 12'h040, 32'h5555_AAAA, 4'h1, 3'b000, 5, 1, rd, er, tm, pl, el, rl, pc, sb);
    checkOutput("t5_first_err", er, 0);
    applyStimulus(nextWrite, nextAddr, nextWdata, nextStrb, nextProt, 0, 0, rd, er, tm, pl, el, rl, pc, sb);
    checkOutput("t5_next_psel_lat", pl, 1);
    checkOutput("t5_next_pstrb", sb, 4'hC);

    $display("[TB] reset during read access");
    slvWait = 6;
    reqWrite = 1'b0; reqAddr = 12'h0A0; reqWdata = 32'h0; reqStrb = 4'hF; reqProt = 3'b000;
    reqVld = 1'b1;
    @(posedge clk); #1;
    reqVld = 1'b0;
    @(posedge clk); #1;
    checkOutput("t6_in_access", mPenable, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("t6_psel", mPsel, 0);
    checkOutput("t6_penable", mPenable, 0);
    checkOutput("t6_rsp_vld", rspVld, 0);
    checkOutput("t6_req_rdy", reqRdy, 1);
    checkOutput("t6_paddr", mPaddr, 0);
    checkOutput("t6_rsp_err", rspErr, 0);
    repeat (3) @(posedge clk);
    #1;
    slvWait = 0; slvData = 32'hCAFE_0006;
    applyStimulus(1'b0, 12'h0A0, 32'h0, 4'hF, 3'b000, 0, 0, rd, er, tm, pl, el, rl, pc, sb);
    checkOutput("t6_after_rdata", rd, 32'hCAFE_0006);
    checkOutput("t6_after_rsp_lat", rl, 3);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
